// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// oversampling constants.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_START  = 7;

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// RESET_VAL sets the flops' value under reset (idle level of the line).
module uart_sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by a 16x oversampling tick. Emits a one-cycle
// done strobe per frame with the received byte and a framing-error flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int NB_DATA     = 8,
  parameter int SB_TICKS    = 16,
  parameter int NB_TICK_CNT = 5,
  parameter int NB_BIT_CNT  = 3
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx,
  input  logic               i_tick,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done,
  output logic               o_frame_err,
  output logic               o_busy
);

  localparam logic [NB_TICK_CNT-1:0] TICK_MID  = NB_TICK_CNT'(MID_START);
  localparam logic [NB_TICK_CNT-1:0] TICK_BIT  = NB_TICK_CNT'(OVERSAMPLE - 1);
  localparam logic [NB_TICK_CNT-1:0] TICK_STOP = NB_TICK_CNT'(SB_TICKS - 1);
  localparam logic [NB_BIT_CNT-1:0]  BIT_LAST  = NB_BIT_CNT'(NB_DATA - 1);

  logic rx_s;

  uart_sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_d    (i_rx),
    .o_q    (rx_s)
  );

  state_t                 state_q,    state_d;
  logic [NB_TICK_CNT-1:0] tick_cnt_q, tick_cnt_d;
  logic [NB_BIT_CNT-1:0]  bit_cnt_q,  bit_cnt_d;
  logic [NB_DATA-1:0]     shift_q,    shift_d;
  logic [NB_DATA-1:0]     data_q,     data_d;
  logic                   done_q,     done_d;
  logic                   ferr_q,     ferr_d;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    done_d     = 1'b0;
    ferr_d     = ferr_q;

    unique case (state_q)
      ST_IDLE: begin
        // Start detection does not wait for a tick.
        if (!rx_s) begin
          state_d    = ST_START;
          tick_cnt_d = '0;
        end
      end
      ST_START: begin
        if (i_tick) begin
          if (tick_cnt_q == TICK_MID) begin
            if (!rx_s) begin
              state_d    = ST_DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (i_tick) begin
          if (tick_cnt_q == TICK_BIT) begin
            shift_d    = {rx_s, shift_q[NB_DATA-1:1]};
            tick_cnt_d = '0;
            if (bit_cnt_q == BIT_LAST) begin
              state_d = ST_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (i_tick) begin
          if (tick_cnt_q == TICK_STOP) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            data_d  = shift_q;
            ferr_d  = ~rx_s;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
    end
  end

  assign o_data      = data_q;
  assign o_rx_done   = done_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of frames plus hand-written glitch and
// mid-frame reset sequences. Tick every 4 clocks, 64 clocks per bit.
module tb_uart_rx;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_rx;
  logic       i_tick;
  logic [7:0] o_data;
  logic       o_rx_done;
  logic       o_frame_err;
  logic       o_busy;

  uart_rx #(
    .NB_DATA    (8),
    .SB_TICKS   (16),
    .NB_TICK_CNT(5),
    .NB_BIT_CNT (3)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_rx       (i_rx),
    .i_tick     (i_tick),
    .o_data     (o_data),
    .o_rx_done  (o_rx_done),
    .o_frame_err(o_frame_err),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  logic       tick_en = 1'b0;
  logic [1:0] tcnt = '0;
  always @(posedge i_clk) if (tick_en) tcnt <= tcnt + 2'd1;
  assign i_tick = tick_en && (tcnt == 2'd3);

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Done-strobe monitor: captures the byte and error flag on each strobe.
  int         done_cnt = 0;
  logic [7:0] cap_data = '0;
  logic       cap_ferr = 1'b0;
  logic       prev_done = 1'b0;
  always @(negedge i_clk) begin
    if (o_rx_done) begin
      done_cnt++;
      cap_data = o_data;
      cap_ferr = o_frame_err;
      check("done_single_cycle", int'(prev_done), 0);
    end
    prev_done = o_rx_done;
  end

  task automatic clks(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_stop, input int freeze_bit);
    i_rx = 1'b0;
    clks(64);
    for (int i = 0; i < 8; i++) begin
      i_rx = d[i];
      if (i == freeze_bit) begin
        clks(16);
        tick_en = 1'b0;
        clks(100);
        check("busy_while_frozen", int'(o_busy), 1);
        check("no_done_while_frozen", int'(o_rx_done), 0);
        tick_en = 1'b1;
        clks(48);
      end else begin
        clks(64);
      end
    end
    if (bad_stop) begin
      // Low across the sample point, high again before the bit ends.
      i_rx = 1'b0;
      clks(40);
      i_rx = 1'b1;
      clks(24);
    end else begin
      i_rx = 1'b1;
      clks(64);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    bit         bad_stop;
    int         freeze_bit;
    bit         gap;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[6];
  int   base;

  initial begin
    vecs[0] = '{data: 8'hA5, bad_stop: 0, freeze_bit: -1, gap: 1, exp_data: 8'hA5, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'h00, bad_stop: 0, freeze_bit: -1, gap: 0, exp_data: 8'h00, exp_ferr: 1'b0};
    vecs[2] = '{data: 8'hFF, bad_stop: 0, freeze_bit: -1, gap: 1, exp_data: 8'hFF, exp_ferr: 1'b0};
    vecs[3] = '{data: 8'h3C, bad_stop: 1, freeze_bit: -1, gap: 1, exp_data: 8'h3C, exp_ferr: 1'b1};
    vecs[4] = '{data: 8'h55, bad_stop: 0, freeze_bit: -1, gap: 1, exp_data: 8'h55, exp_ferr: 1'b0};
    vecs[5] = '{data: 8'h5A, bad_stop: 0, freeze_bit: 3,  gap: 1, exp_data: 8'h5A, exp_ferr: 1'b0};

    i_reset = 1'b1;
    i_rx    = 1'b1;
    @(posedge i_clk);
    #1;
    clks(3);
    check("reset_data", int'(o_data), 0);
    check("reset_done", int'(o_rx_done), 0);
    check("reset_ferr", int'(o_frame_err), 0);
    check("reset_busy", int'(o_busy), 0);
    i_reset = 1'b0;
    tick_en = 1'b1;
    clks(64);

    foreach (vecs[k]) begin
      base = done_cnt;
      send_frame(vecs[k].data, vecs[k].bad_stop, vecs[k].freeze_bit);
      check($sformatf("v%0d_done_count", k), done_cnt - base, 1);
      check($sformatf("v%0d_data", k), int'(cap_data), int'(vecs[k].exp_data));
      check($sformatf("v%0d_ferr", k), int'(cap_ferr), int'(vecs[k].exp_ferr));
      if (vecs[k].gap) begin
        clks(128);
        check($sformatf("v%0d_idle_busy", k), int'(o_busy), 0);
        check($sformatf("v%0d_held_data", k), int'(o_data), int'(vecs[k].exp_data));
      end
    end

    // Short low glitch on an idle line: start bit rejected at mid-point.
    base = done_cnt;
    i_rx = 1'b0;
    clks(6);
    check("glitch_busy", int'(o_busy), 1);
    clks(6);
    i_rx = 1'b1;
    clks(128);
    check("glitch_no_done", done_cnt - base, 0);
    check("glitch_busy_clear", int'(o_busy), 0);
    check("glitch_data_held", int'(o_data), 8'h5A);
    check("glitch_ferr_held", int'(o_frame_err), 0);

    // Reset during bit 4 of 0x81; line returns idle with the reset.
    base = done_cnt;
    i_rx = 1'b0;
    clks(64);
    for (int i = 0; i < 4; i++) begin
      i_rx = (i == 0);
      clks(64);
    end
    i_rx = 1'b0;
    clks(32);
    check("prereset_busy", int'(o_busy), 1);
    i_rx    = 1'b1;
    i_reset = 1'b1;
    clks(1);
    i_reset = 1'b0;
    check("midreset_data", int'(o_data), 0);
    check("midreset_done", int'(o_rx_done), 0);
    check("midreset_ferr", int'(o_frame_err), 0);
    check("midreset_busy", int'(o_busy), 0);
    clks(300);
    check("midreset_no_done", done_cnt - base, 0);

    base = done_cnt;
    send_frame(8'h81, 1'b0, -1);
    clks(64);
    check("after_reset_done_count", done_cnt - base, 1);
    check("after_reset_data", int'(cap_data), 8'h81);
    check("after_reset_ferr", int'(cap_ferr), 0);
    check("after_reset_busy", int'(o_busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
